// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers
// for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned ZERO_REG   = 0;

  function automatic int unsigned slice_lo(
    input int unsigned idx,
    input int unsigned w
  );
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// rf_scoreboard: per-register busy bits,
// set by issue, cleared by writeback.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  localparam int unsigned DEPTH = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic              iss_v,
  input  logic [ADDR_W-1:0] iss_a,
  output logic [DEPTH-1:0]  busy_vec
);

  localparam logic [ADDR_W-1:0] ZA =
    ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy;

  // clear on writeback, then set on issue
  // so a same-edge collision leaves it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (we && wa != ZA)
        busy[wa] <= 1'b0;
      if (iss_v && iss_a != ZA)
        busy[iss_a] <= 1'b1;
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: 1W / NUM_RD-R register file
// with bypass, debug port and scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned NUM_RD = 3,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned DEPTH = 2**ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     iss_v,
  input  logic [ADDR_W-1:0]        iss_a,
  input  logic [ADDR_W-1:0]        dbg_a,
  output logic [DATA_W-1:0]        dbg_d,
  output logic [DEPTH-1:0]         busy_vec
);

  localparam logic [ADDR_W-1:0] ZA =
    ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];

  // storage; reg0 is cleared and never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++)
        mem[k] <= '0;
    end else if (we && wa != ZA) begin
      mem[wa] <= wd;
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wa       (wa),
    .iss_v    (iss_v),
    .iss_a    (iss_a),
    .busy_vec (busy_vec)
  );

  assign dbg_d = mem[dbg_a];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    localparam int unsigned ALO =
      slice_lo(i, ADDR_W);
    localparam int unsigned DLO =
      slice_lo(i, DATA_W);

    logic [ADDR_W-1:0] a;
    logic              nz;
    logic              hit;

    assign a   = ra[ALO +: ADDR_W];
    assign nz  = (a != ZA);
    // reset masks the bypass so rd reads 0
    assign hit = BYPASS && we && !rst
              && nz && (wa == a);

    assign rd[DLO +: DATA_W] =
      !nz ? '0 : hit ? wd : mem[a];
    assign rbusy[i] =
      nz && !hit && busy_vec[a];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vectors against
// bypass and non-bypass register files.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           we = 1'b0;
  logic [AW-1:0]  wa = '0;
  logic [DW-1:0]  wd = '0;
  logic [NR*AW-1:0] ra = '0;
  logic           iss_v = 1'b0;
  logic [AW-1:0]  iss_a = '0;
  logic [AW-1:0]  dbg_a = '0;

  logic [NR*DW-1:0] rd, rd_nb;
  logic [NR-1:0]    rbusy, rbusy_nb;
  logic [DW-1:0]    dbg_d, dbg_d_nb;
  logic [31:0]      bv, bv_nb;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW),
    .NUM_RD(NR), .BYPASS(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd), .rbusy(rbusy),
    .iss_v(iss_v), .iss_a(iss_a),
    .dbg_a(dbg_a), .dbg_d(dbg_d),
    .busy_vec(bv)
  );

  regfile_mp #(
    .DATA_W(DW), .ADDR_W(AW),
    .NUM_RD(NR), .BYPASS(1'b0)
  ) dut_nb (
    .clk(clk), .rst(rst),
    .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb),
    .iss_v(iss_v), .iss_a(iss_a),
    .dbg_a(dbg_a), .dbg_d(dbg_d_nb),
    .busy_vec(bv_nb)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input int p,
                        input int a);
    ra[p*AW +: AW] = AW'(a);
  endtask

  function automatic logic [DW-1:0] rdp(
    input logic [NR*DW-1:0] v,
    input int p
  );
    return v[p*DW +: DW];
  endfunction

  task automatic wr(input int a,
                    input logic [DW-1:0] d);
    we = 1'b1; wa = AW'(a); wd = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    // async reset from time 0
    #1 rst = 1'b1;
    #1;
    check("rst_dbg", dbg_d, 0);
    check("rst_bv", bv, 0);
    check("rst_rd", rd, 0);
    check("rst_rbusy", rbusy, 0);
    @(negedge clk);
    rst = 1'b0;

    // write reg5 and issue reg6
    we = 1'b1; wa = 5; wd = 32'hDEADBEEF;
    iss_v = 1'b1; iss_a = 6;
    tick();
    we = 1'b0; iss_v = 1'b0;
    dbg_a = 5;
    #1;
    check("wr5_dbg", dbg_d, 32'hDEADBEEF);
    check("iss6_bv", bv[6], 1);

    // mid-cycle reset pulse, bypass masked
    #2 rst = 1'b1;
    we = 1'b1; wa = 7; wd = 32'h77;
    set_ra(1, 7);
    #1;
    check("prst_dbg", dbg_d, 0);
    check("prst_bv", bv, 0);
    check("prst_rd1", rdp(rd, 1), 0);
    tick();
    dbg_a = 7;
    #1;
    check("prst_nowr", dbg_d, 0);
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;

    // zero register
    tick();
    we = 1'b1; wa = 0; wd = 32'h12345678;
    set_ra(0, 0);
    iss_v = 1'b1; iss_a = 0;
    #1;
    check("z_rd0_pre", rdp(rd, 0), 0);
    tick();
    we = 1'b0; iss_v = 1'b0;
    dbg_a = 0;
    #1;
    check("z_rd0_post", rdp(rd, 0), 0);
    check("z_dbg", dbg_d, 0);
    check("z_bv", bv, 0);

    // bypass vs stored value
    wr(7, 32'h11111111);
    we = 1'b1; wa = 7; wd = 32'hA5A5A5A5;
    set_ra(1, 7); dbg_a = 7;
    #1;
    check("bp_rd1", rdp(rd, 1), 32'hA5A5A5A5);
    check("bp_dbg", dbg_d, 32'h11111111);
    check("nb_rd1", rdp(rd_nb, 1), 32'h11111111);
    tick();
    we = 1'b0;
    #1;
    check("bp_rd1_post", rdp(rd, 1), 32'hA5A5A5A5);
    check("nb_rd1_post", rdp(rd_nb, 1), 32'hA5A5A5A5);

    // scoreboard set then clear
    iss_v = 1'b1; iss_a = 3;
    set_ra(2, 3);
    #1;
    check("sb_pre", rbusy[2], 0);
    tick();
    iss_v = 1'b0;
    #1;
    check("sb_set", rbusy[2], 1);
    check("sb_set_nb", rbusy_nb[2], 1);
    check("sb_bv3", bv[3], 1);
    we = 1'b1; wa = 3; wd = 9;
    #1;
    check("sb_wb_bp", rbusy[2], 0);
    check("sb_wb_nb", rbusy_nb[2], 1);
    check("sb_wb_rd", rdp(rd, 2), 9);
    tick();
    we = 1'b0;
    #1;
    check("sb_clr_bv3", bv[3], 0);
    check("sb_clr_rd2", rdp(rd, 2), 9);
    check("sb_clr_rb", rbusy[2], 0);

    // collision: set wins, data written
    iss_v = 1'b1; iss_a = 4;
    we = 1'b1; wa = 4; wd = 32'h44;
    tick();
    iss_v = 1'b0; we = 1'b0;
    dbg_a = 4;
    #1;
    check("col_bv4", bv[4], 1);
    check("col_reg4", dbg_d, 32'h44);

    // distinct set/clear, re-issue busy reg
    iss_v = 1'b1; iss_a = 8;
    we = 1'b1; wa = 4; wd = 32'h45;
    tick();
    iss_a = 8; we = 1'b0;
    tick();
    iss_v = 1'b0;
    #1;
    check("dif_bv", bv, 32'h0000_0100);
    check("dif_bv_nb", bv_nb, 32'h0000_0100);

    // fill and sweep all port combinations
    for (int r = 1; r < 32; r++)
      wr(r, DW'(r) * 32'h01010101);
    #1;
    check("fill_bv", bv, 0);
    for (int a0 = 0; a0 < 32; a0++)
      for (int a1 = 0; a1 < 32; a1++)
        for (int a2 = 0; a2 < 32; a2++) begin
          set_ra(0, a0);
          set_ra(1, a1);
          set_ra(2, a2);
          #1;
          check("sw_rd0", rdp(rd, 0),
                DW'(a0) * 32'h01010101);
          check("sw_rd1", rdp(rd, 1),
                DW'(a1) * 32'h01010101);
          check("sw_rd2", rdp(rd, 2),
                DW'(a2) * 32'h01010101);
        end

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the pipelined CPU datapath.
- One synchronous write port, NUM_RD asynchronous read ports and one asynchronous debug read port.
- Optional write-to-read bypass, so the writeback stage and decode stage agree in the same cycle.
- Built-in per-register busy scoreboard that decode uses for hazard stalls.
- Register 0 is hardwired to zero; all storage clears on reset.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 3, number of operand read ports (>=1)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write enable
- wa  in  ADDR_W  write address
- wd  in  DATA_W  write data
- ra  in  NUM_RD*ADDR_W  packed read addresses; port i = ra[i*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  packed read data, same packing as ra
- rbusy  out  NUM_RD  port i's source register has a pending producer
- iss_v  in  1  issue: mark register iss_a busy
- iss_a  in  ADDR_W  destination of issued instruction
- dbg_a  in  ADDR_W  debug read address
- dbg_d  out  DATA_W  debug read data; never bypassed
- busy_vec  out  2**ADDR_W  raw scoreboard bits, bit 0 always 0

Behaviour:
- Reset (rst=1, async):
  - All registers are cleared to 0 and all busy bits to 0, immediately, independent of clk.
  - While rst is held: rd=0, dbg_d=0, rbusy=0, busy_vec=0.
  - Writes and issues are ignored.
- Reset deassert mid-operation: the first rising edge with rst=0 behaves normally; no pending state survives.
- Write:
  - On posedge with we=1 and wa!=0: reg[wa] <= wd.
  - wa=0 writes are discarded; reg[0] reads 0 always.
  - Write latency is 1 cycle: the stored value is visible on dbg_d after the edge.
- Read (combinational, per port i, address a=ra_i):
  - a=0 -> 0.
  - Else if BYPASS=1, we=1 and wa=a -> wd.
  - Else -> reg[a].
  - Multiple ports may read the same address; all get identical data.
- Scoreboard:
  - Set: posedge with iss_v=1 and iss_a!=0 -> busy[iss_a] <= 1.
  - Clear: posedge with we=1 and wa!=0 -> busy[wa] <= 0.
  - Same edge, iss_a=wa: set wins (newer producer); result is busy=1.
  - Same edge, different addresses: both take effect.
  - Issue to an already-busy register: stays 1, no error.
  - iss_a=0 and wa=0: no effect.
- rbusy_i:
  - = busy[a] for a!=0, and 0 when a=0.
  - If BYPASS=1 and we=1 and wa=a: rbusy_i=0 (the value is being forwarded this cycle).
- Widths: no arithmetic; all address compares are full ADDR_W equality. Depth is a power of two, so there is no out-of-range address.

Decomposition:
- Package regfile_pkg: default DATA_W/ADDR_W, the zero-register index constant, and the function to extract a packed port slice.
- Sub-module rf_scoreboard: holds busy bits; set/clear priority logic; busy_vec output.
- Storage, read muxing and bypass stay in the top module.

Test Plan:
- Reset clears:
  - Stimulus: write reg5=0xDEADBEEF, then pulse rst between clock edges.
  - Required: dbg_a=5 reads 0 immediately, and busy_vec=0.
- Zero register:
  - Stimulus: we=1, wa=0, wd=0x12345678, then read ra0=0.
  - Required: rd0=0 before and after the edge.
- Bypass (BYPASS=1):
  - Stimulus: we=1, wa=7, wd=0xA5A5A5A5, ra1=7 in the same cycle.
  - Required: rd1=0xA5A5A5A5 and dbg_d (a=7) = old value before the edge.
  - With BYPASS=0: rd1 = old value before the edge.
- Scoreboard set/clear:
  - Stimulus: iss_v=1, iss_a=3; then ra2=3.
  - Required: after the edge, rbusy2=1.
  - Stimulus: writeback we=1, wa=3, wd=9.
  - Required: rbusy2=0 during that cycle (bypass); after the edge busy_vec[3]=0 and rd2=9.
- Set/clear collision:
  - Stimulus: iss_v=1, iss_a=4, we=1, wa=4 on the same edge.
  - Required: busy_vec[4]=1 after the edge and reg4=wd.
- All ports:
  - Stimulus: NUM_RD=3, fill reg1..reg31 with value = index*0x01010101, sweep all ra combinations including duplicates.
  - Required: every rd_i matches the model; reg0 reads 0.
